// File: rtl/seq_unlock_pkg.sv
// Shared types and constants for the sequential unlock controller.
// The LFSR constants are only consumed when SEQ_UNLOCK_SCRAMBLE_EN is defined.
package seq_unlock_pkg;

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_UNLOCKED = 2'd1,
      ST_LOCKOUT  = 2'd2
   } state_t;

   // Polynomial x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask on bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] LFSR_SEED = 8'h01;

   // One left shift of the LFSR with the XOR of the tapped bits fed into bit 0
   function automatic logic [7:0] lfsrNext(input logic [7:0] q);
      return {q[6:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/seq_unlock_lfsr.sv
// 8-bit scrambling LFSR, stepping once per asserted adv.
// Only instantiated when SEQ_UNLOCK_SCRAMBLE_EN is defined.
module seq_unlock_lfsr
   import seq_unlock_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv,
   output logic [7:0] q
);

   logic [7:0] r_lfsr;

   // Advance the sequence on each request; reset returns to the fixed seed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else if (adv) begin
         r_lfsr <= lfsrNext(r_lfsr);
      end
   end

   assign q = r_lfsr;

endmodule

// File: rtl/seq_unlock_ctrl.sv
// Sequential unlock controller: a fixed series of symbol reads inside an
// address window unlocks the block; repeated wrong symbols cause a timed
// lockout. Define SEQ_UNLOCK_SCRAMBLE_EN to XOR the readback with an LFSR.
module seq_unlock_ctrl
   import seq_unlock_pkg::*;
#(
   parameter int                          ADDR_W      = 14,
   parameter logic [ADDR_W-1:0]           SEL_MASK    = 14'h3000,
   parameter logic [ADDR_W-1:0]           SEL_MATCH   = 14'h1000,
   parameter int                          NIB_W       = 4,
   parameter int                          NIB_LSB     = 4,
   parameter int                          KEY_LEN     = 6,
   parameter logic [KEY_LEN*NIB_W-1:0]    KEY         = 24'h29BA35,
   parameter logic [NIB_W-1:0]            RELOCK_NIB  = 4'hF,
   parameter int                          MAX_FAIL    = 3,
   parameter int                          LOCKOUT_CYC = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         bus_valid,
   input  logic                         bus_rd,
   input  logic [ADDR_W-1:0]            bus_addr,
   input  logic                         sser,
   output logic [1:0]                   rdata,
   output logic                         rdata_oe,
   output logic                         unlocked,
   output logic                         lockout,
   output logic [$clog2(KEY_LEN+1)-1:0] step
);

   localparam int STEP_W  = $clog2(KEY_LEN+1);
   localparam int FAIL_W  = $clog2(MAX_FAIL+1);
   localparam int TIMER_W = $clog2(LOCKOUT_CYC+1);

   localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(KEY_LEN-1);
   localparam logic [STEP_W-1:0]  STEP_FULL = STEP_W'(KEY_LEN);
   localparam logic [FAIL_W-1:0]  FAIL_LAST = FAIL_W'(MAX_FAIL-1);
   localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(LOCKOUT_CYC-1);
   localparam logic [NIB_W-1:0]   KEY_FIRST = KEY[(KEY_LEN-1)*NIB_W +: NIB_W];

   state_t              r_state;
   state_t              w_stateNxt;
   logic [STEP_W-1:0]   r_step;
   logic [STEP_W-1:0]   w_stepNxt;
   logic [FAIL_W-1:0]   r_fail;
   logic [FAIL_W-1:0]   w_failNxt;
   logic [TIMER_W-1:0]  r_timer;
   logic [TIMER_W-1:0]  w_timerNxt;
   logic [1:0]          r_rdata;
   logic [1:0]          w_rdataNxt;
   logic                r_rdataOe;
   logic                w_qual;
   logic [NIB_W-1:0]    w_sym;
   logic [NIB_W-1:0]    w_expSym;
   logic [1:0]          w_rdataRaw;

   assign w_qual = bus_valid & bus_rd & ~sser & ((bus_addr & SEL_MASK) == SEL_MATCH);
   assign w_sym  = bus_addr[NIB_LSB +: NIB_W];

`ifdef SEQ_UNLOCK_SCRAMBLE_EN
   logic [7:0] w_lfsr;

   seq_unlock_lfsr u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (w_qual),
      .q     (w_lfsr)
   );

   assign w_rdataRaw = w_lfsr[1:0] ^ {(r_state == ST_UNLOCKED), ^r_step};
`else
   assign w_rdataRaw = {(r_state == ST_UNLOCKED), r_step[0]};
`endif

   // Pick the key symbol expected at the current step (constant selects only)
   always_comb begin
      w_expSym = '0;
      for (int k = 0; k < KEY_LEN; k++) begin
         if (r_step == STEP_W'(k)) begin
            w_expSym = KEY[(KEY_LEN-1-k)*NIB_W +: NIB_W];
         end
      end
   end

   // Next-state logic: matching only on qualifying reads, timer runs freely in lockout
   always_comb begin
      w_stateNxt = r_state;
      w_stepNxt  = r_step;
      w_failNxt  = r_fail;
      w_timerNxt = r_timer;
      case (r_state)
         ST_LOCKED: begin
            if (w_qual) begin
               if (w_sym == w_expSym) begin
                  w_failNxt = '0;
                  if (r_step == STEP_LAST) begin
                     w_stateNxt = ST_UNLOCKED;
                     w_stepNxt  = STEP_FULL;
                  end else begin
                     w_stepNxt = r_step + STEP_W'(1);
                  end
               end else begin
                  w_stepNxt = (w_sym == KEY_FIRST) ? STEP_W'(1) : '0;
                  w_failNxt = r_fail + FAIL_W'(1);
                  if (r_fail == FAIL_LAST) begin
                     w_stateNxt = ST_LOCKOUT;
                     w_stepNxt  = '0;
                     w_timerNxt = TIMER_INIT;
                  end
               end
            end
         end
         ST_UNLOCKED: begin
            if (w_qual && (w_sym == RELOCK_NIB)) begin
               w_stateNxt = ST_LOCKED;
               w_stepNxt  = '0;
            end
         end
         ST_LOCKOUT: begin
            if (r_timer == '0) begin
               w_stateNxt = ST_LOCKED;
               w_failNxt  = '0;
            end else begin
               w_timerNxt = r_timer - TIMER_W'(1);
            end
         end
         default: begin
            w_stateNxt = ST_LOCKED;
            w_stepNxt  = '0;
            w_failNxt  = '0;
            w_timerNxt = '0;
         end
      endcase
   end

   // Readback is taken from the state before this access updates it; lockout reads as zero
   always_comb begin
      w_rdataNxt = 2'b00;
      if (w_qual && (r_state != ST_LOCKOUT)) begin
         w_rdataNxt = w_rdataRaw;
      end
   end

   // State, counters and registered readback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_LOCKED;
         r_step    <= '0;
         r_fail    <= '0;
         r_timer   <= '0;
         r_rdata   <= 2'b00;
         r_rdataOe <= 1'b0;
      end else begin
         r_state   <= w_stateNxt;
         r_step    <= w_stepNxt;
         r_fail    <= w_failNxt;
         r_timer   <= w_timerNxt;
         r_rdata   <= w_rdataNxt;
         r_rdataOe <= w_qual;
      end
   end

   assign rdata    = r_rdata;
   assign rdata_oe = r_rdataOe;
   assign unlocked = (r_state == ST_UNLOCKED);
   assign lockout  = (r_state == ST_LOCKOUT);
   assign step     = r_step;

endmodule

// File: tb/tb_seq_unlock_ctrl.sv
// Self-checking bench for seq_unlock_ctrl: directed key sequences followed by
// random bus traffic, compared against a behavioural model of the lock rules.
// Readback is checked through a scoreboard queue drained by a monitor process.
module tb_seq_unlock_ctrl;

   logic        clk;
   logic        rst_n;
   logic        bus_valid;
   logic        bus_rd;
   logic [13:0] bus_addr;
   logic        sser;
   logic [1:0]  rdata;
   logic        rdata_oe;
   logic        unlocked;
   logic        lockout;
   logic [2:0]  step;

   seq_unlock_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_valid (bus_valid),
      .bus_rd    (bus_rd),
      .bus_addr  (bus_addr),
      .sser      (sser),
      .rdata     (rdata),
      .rdata_oe  (rdata_oe),
      .unlocked  (unlocked),
      .lockout   (lockout),
      .step      (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChecks = 0;
   int nPass   = 0;

   // Reference model of the lock, tracked as plain integers
   int keySyms[6] = '{2, 9, 11, 10, 3, 5};
   int mStep      = 0;
   int mFails     = 0;
   int mLockLeft  = 0;
   bit mUnlocked  = 0;
   int mLfsr      = 1;

   logic [1:0] expQ[$];

   task automatic checkOutput(input string name, input int got, input int exp);
      nChecks++;
      if (got == exp) nPass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   function automatic void modelReset();
      mStep = 0; mFails = 0; mLockLeft = 0; mUnlocked = 0; mLfsr = 1;
   endfunction

   // Expected readback for an access made in the current model state
   function automatic logic [1:0] modelRdata();
      logic [1:0] r;
      if (mLockLeft > 0) return 2'b00;
`ifdef SEQ_UNLOCK_SCRAMBLE_EN
      r = 2'(mLfsr & 3) ^ {mUnlocked, 1'($countones(mStep) & 1)};
`else
      r = {mUnlocked, 1'(mStep % 2)};
`endif
      return r;
   endfunction

   // One clock edge worth of lock rules
   function automatic void modelEdge(input bit qual, input int sym);
      if (qual) begin
         mLfsr = ((mLfsr << 1) & 8'hFE) |
                 (((mLfsr >> 7) ^ (mLfsr >> 5) ^ (mLfsr >> 4) ^ (mLfsr >> 3)) & 1);
      end
      if (mLockLeft > 0) begin
         mLockLeft--;
         if (mLockLeft == 0) mFails = 0;
      end else if (qual) begin
         if (mUnlocked) begin
            if (sym == 15) begin
               mUnlocked = 0;
               mStep = 0;
            end
         end else if (sym == keySyms[mStep]) begin
            mFails = 0;
            mStep++;
            if (mStep == 6) mUnlocked = 1;
         end else begin
            mStep = (sym == keySyms[0]) ? 1 : 0;
            mFails++;
            if (mFails == 3) begin
               mLockLeft = 256;
               mStep = 0;
            end
         end
      end
   endfunction

   // Drive one cycle of bus inputs, advance the model, then check state outputs
   task automatic applyStimulus(input bit v, input bit rd, input logic [13:0] addr, input bit inh);
      bit qual;
      @(negedge clk);
      bus_valid = v;
      bus_rd    = rd;
      bus_addr  = addr;
      sser      = inh;
      qual = v && rd && !inh && ((addr & 14'h3000) == 14'h1000);
      if (qual) expQ.push_back(modelRdata());
      modelEdge(qual, int'(addr[7:4]));
      @(posedge clk);
      #1;
      checkOutput("step", int'(step), mStep);
      checkOutput("unlocked", int'(unlocked), int'(mUnlocked));
      checkOutput("lockout", int'(lockout), int'(mLockLeft > 0));
   endtask

   task automatic readSym(input int n);
      applyStimulus(1'b1, 1'b1, 14'h1000 | 14'(n << 4), 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 14'h0000, 1'b0);
   endtask

   task automatic readKey();
      for (int i = 0; i < 6; i++) readSym(keySyms[i]);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear immediately
   task automatic pulseReset(input int holdCycles);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_step", int'(step), 0);
      checkOutput("rst_unlocked", int'(unlocked), 0);
      checkOutput("rst_lockout", int'(lockout), 0);
      checkOutput("rst_rdata_oe", int'(rdata_oe), 0);
      checkOutput("rst_rdata", int'(rdata), 0);
      expQ.delete();
      modelReset();
      repeat (holdCycles) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every readback pulse must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (rdata_oe) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpected_rdata_oe", 1, 0);
               end else begin
                  checkOutput("rdata", int'(rdata), int'(expQ.pop_front()));
               end
            end else begin
               checkOutput("rdata_idle", int'(rdata), 0);
            end
         end
      end
   end

   initial begin
      bit v, rd, inh;
      logic [13:0] addr;
      int sym;
      bus_valid = 1'b0;
      bus_rd    = 1'b0;
      bus_addr  = '0;
      sser      = 1'b0;
      rst_n     = 1'b0;
      #1;
      checkOutput("init_step", int'(step), 0);
      checkOutput("init_unlocked", int'(unlocked), 0);
      checkOutput("init_rdata_oe", int'(rdata_oe), 0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;

`ifdef SEQ_UNLOCK_SCRAMBLE_EN
      readSym(0);
      readSym(0);
      idle(2);
      pulseReset(1);
`endif

      // Full key from reset, then relock and non-qualifying accesses
      readKey();
      idle(1);
      readSym(15);
      applyStimulus(1'b1, 1'b1, 14'h1040, 1'b1);
      applyStimulus(1'b1, 1'b0, 14'h1040, 1'b0);
      applyStimulus(1'b1, 1'b1, 14'h2040, 1'b0);
      applyStimulus(1'b0, 1'b1, 14'h1020, 1'b0);

      // Restart mid-sequence on a repeated first symbol
      readSym(2); readSym(9); readSym(2); readSym(9);
      readSym(11); readSym(10); readSym(3); readSym(5);
      readSym(4);
      readSym(15);

      // Three wrong symbols lock out; key is ignored until the timer expires
      readSym(7); readSym(7); readSym(7);
      readKey();
      idle(252);
      readKey();
      readSym(15);

      // Reset partway through the key discards progress
      readSym(2); readSym(9); readSym(11); readSym(10);
      idle(1);
      pulseReset(3);
      readSym(2);

      // Random traffic biased toward the window and the expected symbol
      for (int i = 0; i < 1500; i++) begin
         v    = ($urandom_range(0, 3) != 0);
         rd   = ($urandom_range(0, 7) != 0);
         inh  = ($urandom_range(0, 9) == 0);
         addr = 14'($urandom);
         if ($urandom_range(0, 5) != 0) addr = (addr & 14'h0FFF) | 14'h1000;
         case ($urandom_range(0, 3))
            0, 1:    sym = (mStep < 6) ? keySyms[mStep] : 15;
            2:       sym = keySyms[0];
            default: sym = int'($urandom_range(0, 15));
         endcase
         addr[7:4] = 4'(sym);
         applyStimulus(v, rd, addr, inh);
      end

      idle(2);
      checkOutput("queue_drained", expQ.size(), 0);
      $display("[TB] %0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/seq_unlock_ctrl.md
SEQ_UNLOCK_CTRL -- requirements
Module: seq_unlock_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  ADDR_W, 14, bus address width
  SEL_MASK, 14'h3000, address bits compared for window select
  SEL_MATCH, 14'h1000, required value of masked address
  NIB_W, 4, key symbol width
  NIB_LSB, 4, LSB of key symbol within bus_addr
  KEY_LEN, 6, symbols in unlock sequence (2..16)
  KEY, 24'h29BA35, flat key, symbol k = KEY[(KEY_LEN-1-k)*NIB_W +: NIB_W]
  RELOCK_NIB, 4'hF, symbol that relocks when unlocked
  MAX_FAIL, 3, consecutive mismatches before lockout
  LOCKOUT_CYC, 256, lockout duration in clk cycles
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clk  in  1  clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  bus_valid  in  1  one-cycle strobe per bus access
  bus_rd  in  1  1 = read access
  bus_addr  in  ADDR_W  access address
  sser  in  1  1 = inhibit, access ignored
  rdata  out  2  readback bits
  rdata_oe  out  1  rdata drive enable
  unlocked  out  1  sequence complete
  lockout  out  1  lockout active
  step  out  $clog2(KEY_LEN+1)  symbols matched so far

Function
REQ-003 Qualifying access SHALL be bus_valid & bus_rd & ~sser & ((bus_addr & SEL_MASK) == SEL_MATCH); symbol = bus_addr[NIB_LSB +: NIB_W].
REQ-004 States SHALL be LOCKED, UNLOCKED, LOCKOUT; all transitions on qualifying accesses or lockout expiry only.
REQ-005 LOCKED, step k: symbol == key[k] -> step k+1, fail count cleared; k+1 == KEY_LEN -> UNLOCKED, step = KEY_LEN.
REQ-006 LOCKED mismatch: step = 1 if symbol == key[0] else 0; fail count +1; fail count reaching MAX_FAIL -> LOCKOUT, step 0.
REQ-007 LOCKOUT: timer loads LOCKOUT_CYC-1, decrements every cycle; qualifying accesses ignored for matching; timer 0 -> LOCKED, fail count 0.
REQ-008 UNLOCKED: symbol == RELOCK_NIB -> LOCKED, step 0; any other symbol holds UNLOCKED.
REQ-009 Non-qualifying cycles SHALL leave state, step, fail count unchanged (except LOCKOUT timer).
REQ-010 rdata/rdata_oe SHALL be registered: rdata_oe high exactly the cycle after a qualifying access, rdata computed from pre-update state; rdata_oe low otherwise, rdata 2'b00 when rdata_oe low.
REQ-011 rdata SHALL be 2'b00 for accesses during LOCKOUT.
REQ-012 unlocked, lockout, step SHALL reflect current state register, zero latency from state.

Reset
REQ-013 rst_n low SHALL asynchronously force LOCKED, step 0, fail count 0, timer 0, rdata 2'b00, rdata_oe 0, unlocked 0, lockout 0, LFSR 8'h01; reset mid-sequence discards progress.

Configuration
REQ-014 With SEQ_UNLOCK_SCRAMBLE_EN defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1) SHALL advance once per qualifying access; rdata = lfsr[1:0] ^ {unlocked, ^step}, using pre-advance LFSR.
REQ-015 Without SEQ_UNLOCK_SCRAMBLE_EN: no LFSR; rdata = {unlocked, step[0]}.

Structure
REQ-016 Package seq_unlock_pkg SHALL hold state enum and LFSR polynomial/seed constants.
REQ-017 LFSR SHALL be sub-module seq_unlock_lfsr (clk, rst_n, adv, q[7:0]), instantiated only under SEQ_UNLOCK_SCRAMBLE_EN.

Verification (defaults; symbol n accessed at 14'h1000 | n<<4)
REQ-018 Reads 2,9,B,A,3,5 -> step 1..6, unlocked=1 after 6th; scramble off: rdata after 6th read = 2'b01.
REQ-019 Reads 2,9,2,9,B,A,3,5 -> step 1,2,1,2,3,4,5,6, unlocked=1, one fail recorded.
REQ-020 Reads 7,7,7 -> lockout=1 after 3rd; full key during lockout -> step stays 0, rdata 2'b00; after 256 cycles lockout=0, full key unlocks.
REQ-021 Unlocked, read F -> unlocked=0, step 0; read 0x1040 with sser=1 or bus_rd=0 or addr 0x2040 -> no change, rdata_oe stays 0.
REQ-022 rst_n low mid-sequence (step 4) for any duration -> all outputs reset same cycle; next read 2 -> step 1.
REQ-023 Scramble on: two reads of 0 from reset -> rdata 2'b01 then 2'b10 (LFSR 01, 02).
